// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared types and constants for the cache line adaptor
package cacheline_adaptor_pkg;

  localparam int unsigned S_LINE    = 256;
  localparam int unsigned S_BURST   = 64;
  localparam int unsigned BEATS     = S_LINE / S_BURST;
  localparam int unsigned CNT_W     = $clog2(BEATS);
  localparam int unsigned OFFSET_W  = $clog2(S_LINE / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_t;

  // Memory bursts always start at the first byte of the cache line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << OFFSET_W) - 32'd1);
  endfunction

endpackage

// File: rtl/cacheline_adaptor_register.sv
// rtl/cacheline_adaptor_register.sv - wide register loaded one slice at a time
module cacheline_adaptor_register #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned SLICE = 64,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [SLICE-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // Unselected slices keep their old contents until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q[idx_i*SLICE +: SLICE] <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts cache line requests into 4-beat memory bursts
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned s_line  = S_LINE,
  parameter int unsigned s_burst = S_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  adaptor_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [s_line-1:0] wline_q, wline_d;
  logic              load_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    load_beat = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Writeback wins so a dirty victim leaves before its replacement arrives.
        if (write_i) begin
          wline_d = line_i;
          addr_d  = line_align(address_i);
          state_d = WR;
        end else if (read_i) begin
          addr_d  = line_align(address_i);
          state_d = RD;
        end
      end
      RD: begin
        read_o = 1'b1;
        if (resp_i) begin
          load_beat = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  cacheline_adaptor_register #(
    .WIDTH (s_line),
    .SLICE (s_burst),
    .IDX_W (CNT_W)
  ) u_line_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_beat),
    .idx_i  (cnt_q),
    .data_i (burst_i),
    .data_o (line_o)
  );

  assign burst_o   = wline_q[cnt_q*s_burst +: s_burst];
  assign address_o = addr_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int errors = 0;
  int checks = 0;
  logic [255:0] exp_line = '0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] align_model(input logic [31:0] a);
    return a - (a % 32);
  endfunction

  // Entered at a negedge with the DUT idle; the request is accepted at the next posedge.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] beats,
                          input bit rnd, input logic [31:0] mask);
    logic [31:0] aligned;
    int k;
    bit done;
    aligned = align_model(addr);
    k = 0;
    done = 1'b0;
    read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
    for (int c = 1; c < 64 && !done; c++) begin
      @(negedge clk);
      address_i = $urandom;
      line_i = rand256();
      if (k < 4) begin
        check("rd_read_o", read_o, 1'b1);
        check("rd_resp_o_low", resp_o, 1'b0);
        check("rd_address_o", address_o, aligned);
        check("rd_line_o_progress", line_o, exp_line);
        resp_i = rnd ? 1'($urandom_range(0, 1)) : ((c < 32) ? mask[c] : 1'b0);
        burst_i = resp_i ? beats[64*k +: 64] : {$urandom, $urandom};
        if (resp_i) begin
          exp_line[64*k +: 64] = beats[64*k +: 64];
          k++;
        end
      end else begin
        check("rd_resp_o", resp_o, 1'b1);
        check("rd_read_o_drop", read_o, 1'b0);
        check("rd_line_o", line_o, exp_line);
        read_i = 1'b0;
        resp_i = 1'($urandom_range(0, 1));
        done = 1'b1;
      end
    end
    if (!done) check("rd_timeout", 1'b0, 1'b1);
    @(negedge clk);
    resp_i = 1'b0;
    check("rd_idle_resp_o", resp_o, 1'b0);
    check("rd_idle_read_o", read_o, 1'b0);
    check("rd_idle_write_o", write_o, 1'b0);
    check("rd_idle_line_o", line_o, exp_line);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input bit both, input bit rnd, input logic [31:0] mask);
    logic [31:0] aligned;
    int k;
    bit done;
    aligned = align_model(addr);
    k = 0;
    done = 1'b0;
    write_i = 1'b1; read_i = both; line_i = line; address_i = addr; resp_i = 1'b0;
    for (int c = 1; c < 64 && !done; c++) begin
      @(negedge clk);
      address_i = $urandom;
      line_i = rand256();
      burst_i = {$urandom, $urandom};
      if (k < 4) begin
        check("wr_write_o", write_o, 1'b1);
        check("wr_read_o_low", read_o, 1'b0);
        check("wr_resp_o_low", resp_o, 1'b0);
        check("wr_address_o", address_o, aligned);
        check("wr_burst_o", burst_o, line[64*k +: 64]);
        check("wr_line_o_kept", line_o, exp_line);
        resp_i = rnd ? 1'($urandom_range(0, 1)) : ((c < 32) ? mask[c] : 1'b0);
        if (resp_i) k++;
      end else begin
        check("wr_resp_o", resp_o, 1'b1);
        check("wr_write_o_drop", write_o, 1'b0);
        check("wr_line_o", line_o, exp_line);
        write_i = 1'b0;
        resp_i = 1'($urandom_range(0, 1));
        done = 1'b1;
      end
    end
    if (!done) check("wr_timeout", 1'b0, 1'b1);
    @(negedge clk);
    resp_i = 1'b0;
    check("wr_idle_resp_o", resp_o, 1'b0);
    check("wr_idle_read_o", read_o, 1'b0);
    check("wr_idle_write_o", write_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [255:0] rd_beats;
    logic [255:0] wr_line;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    repeat (2) @(negedge clk);
    check("rst_read_o", read_o, 1'b0);
    check("rst_write_o", write_o, 1'b0);
    check("rst_resp_o", resp_o, 1'b0);
    check("rst_address_o", address_o, 32'h0);
    check("rst_line_o", line_o, 256'h0);
    check("rst_burst_o", burst_o, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    rd_beats = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_read(32'h0000_1000, rd_beats, 1'b0, 32'h0000_001E);
    check("read_basic_line", line_o, rd_beats);

    wr_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_write(32'h0000_2040, wr_line, 1'b0, 1'b0, 32'h0000_001E);

    run_read(32'h0000_3000, rand256(), 1'b0, 32'h0000_0298);

    run_write(32'h0000_4000, rand256(), 1'b1, 1'b0, 32'h0000_001E);
    run_read(32'h0000_5000, rand256(), 1'b0, 32'h0000_001E);

    run_read(32'h1234_567F, rand256(), 1'b0, 32'h0000_0298);

    read_i = 1'b1; address_i = 32'h0000_6000; resp_i = 1'b0;
    rd_beats = rand256();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      resp_i = 1'b1;
      burst_i = rd_beats[64*(c-1) +: 64];
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_read_o", read_o, 1'b0);
    check("rst_mid_resp_o", resp_o, 1'b0);
    check("rst_mid_line_o", line_o, 256'h0);
    check("rst_mid_address_o", address_o, 32'h0);
    check("rst_mid_burst_o", burst_o, 64'h0);
    read_i = 1'b0; resp_i = 1'b0;
    exp_line = '0;
    @(negedge clk);
    check("rst_hold_resp_o", resp_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_read_o", read_o, 1'b0);
    check("post_rst_resp_o", resp_o, 1'b0);
    run_read(32'h0000_7020, rand256(), 1'b0, 32'h0000_001E);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0: run_read($urandom, rand256(), 1'b1, 32'h0);
        1: run_write($urandom, rand256(), 1'b0, 1'b1, 32'h0);
        default: begin
          run_write($urandom, rand256(), 1'b1, 1'b1, 32'h0);
          run_read($urandom, rand256(), 1'b1, 32'h0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
